// File: rtl/stack_pkg.sv
// Shared types for the stack sequencer: opcodes, FSM states and per-opcode decode.
// No ports; imported by stack_op_sequencer, stack_alu and the bench.
package stack_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_DEPTH  = 256;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_DUP  = 3'd6,
        OP_PEEK = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_B,
        S_RD_A,
        S_LAT_A,
        S_LAT_B,
        S_WR
    } state_e;

    // min_depth: entries that must already be on the stack
    // grows:     net occupancy +1, so the stack must not be full
    // pushes:    a result is written back
    typedef struct packed {
        logic [1:0] min_depth;
        logic       grows;
        logic       pushes;
    } op_info_t;

    function automatic op_info_t op_decode(input opcode_e op);
        op_info_t info;
        info = '0;
        case (op)
            OP_PUSH: begin
                info.grows  = 1'b1;
                info.pushes = 1'b1;
            end
            OP_POP, OP_PEEK: begin
                info.min_depth = 2'd1;
            end
            OP_DUP: begin
                info.min_depth = 2'd1;
                info.grows     = 1'b1;
                info.pushes    = 1'b1;
            end
            default: begin
                info.min_depth = 2'd2;
                info.pushes    = 1'b1;
            end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for the binary stack ops; y = a op b, non-ALU opcodes pass b.
// Ports: opcode (operation), a (entry below top), b (old top), y (result).
module stack_alu
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  opcode_e           opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = b;
        case (opcode)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = b;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Stack-machine sequencer driving push/pop/top strobes of an external LIFO.
// Ports: clk, rst (async, active-high); instr_valid/instr_ready/opcode/imm
// instruction handshake; stk_push/stk_pop/stk_top/stk_din/stk_dout stack side;
// result/result_valid completion; err sticky illegal-op flag; depth occupancy.
module stack_op_sequencer
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            opcode,
    input  logic [DATA_W-1:0]     imm,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic                  stk_top,
    output logic [DATA_W-1:0]     stk_din,
    input  logic [DATA_W-1:0]     stk_dout,
    output logic [DATA_W-1:0]     result,
    output logic                  result_valid,
    output logic                  err,
    output logic [$clog2(DEPTH):0] depth
);

    localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;

    state_e            state, state_nx;
    opcode_e           op_in, op_q;
    op_info_t          info;
    logic [DATA_W-1:0] b_q, alu_y, din_nx, res_nx;
    logic              push_nx, pop_nx, top_nx, done_nx, illegal, accept;

    assign op_in = opcode_e'(opcode);

    stack_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (op_q),
        .a      (stk_dout),
        .b      (b_q),
        .y      (alu_y)
    );

    // Next state, next strobes, write data and completion
    always_comb begin
        state_nx = state;
        push_nx  = 1'b0;
        pop_nx   = 1'b0;
        top_nx   = 1'b0;
        done_nx  = 1'b0;
        illegal  = 1'b0;
        accept   = 1'b0;
        din_nx   = '0;
        res_nx   = result;
        info     = op_decode((state == S_IDLE) ? op_in : op_q);
        case (state)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    accept = 1'b1;
                    if ((depth < DEPTH_W'(info.min_depth)) ||
                        (info.grows && (depth >= DEPTH_W'(DEPTH)))) begin
                        illegal = 1'b1;
                    end else if (op_in == OP_PUSH) begin
                        state_nx = S_WR;
                        push_nx  = 1'b1;
                        din_nx   = imm;
                    end else begin
                        state_nx = S_RD_B;
                        if (op_in == OP_DUP || op_in == OP_PEEK) top_nx = 1'b1;
                        else                                     pop_nx = 1'b1;
                    end
                end
            end
            S_RD_B: begin
                // binary ops are the only ones needing a second operand
                if (info.min_depth == 2'd2) begin
                    state_nx = S_RD_A;
                    pop_nx   = 1'b1;
                end else begin
                    state_nx = S_LAT_B;
                end
            end
            S_RD_A: state_nx = S_LAT_A;
            S_LAT_A: begin
                state_nx = S_WR;
                push_nx  = 1'b1;
                din_nx   = alu_y;
            end
            S_LAT_B: begin
                if (info.pushes) begin
                    state_nx = S_WR;
                    push_nx  = 1'b1;
                    din_nx   = stk_dout;
                end else begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                    res_nx   = stk_dout;
                end
            end
            S_WR: begin
                state_nx = S_IDLE;
                done_nx  = 1'b1;
                res_nx   = stk_din;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, registered outputs, operand latch and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= OP_PUSH;
            b_q          <= '0;
            instr_ready  <= 1'b0;
            stk_push     <= 1'b0;
            stk_pop      <= 1'b0;
            stk_top      <= 1'b0;
            stk_din      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            depth        <= '0;
        end else begin
            state        <= state_nx;
            instr_ready  <= (state_nx == S_IDLE);
            stk_push     <= push_nx;
            stk_pop      <= pop_nx;
            stk_top      <= top_nx;
            stk_din      <= din_nx;
            result       <= res_nx;
            result_valid <= done_nx;
            if (illegal) err <= 1'b1;
            if (accept) op_q <= op_in;
            if (state == S_RD_A) b_q <= stk_dout;
            case ({stk_push, stk_pop})
                2'b10:   depth <= depth + DEPTH_W'(1);
                2'b01:   depth <= depth - DEPTH_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: a behavioural LIFO answers the strobes, a queue
// model predicts results, and directed tables plus random ops are checked.
module tb_stack_op_sequencer;
    import stack_pkg::*;

    logic       clk, rst, instr_valid, instr_ready;
    logic [2:0] opcode;
    logic [7:0] imm, stk_din, stk_dout, result;
    logic       stk_push, stk_pop, stk_top, result_valid, err;
    logic [8:0] depth;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] P_PUSH = 2'd1;
    localparam logic [1:0] P_POP  = 2'd2;
    localparam logic [1:0] P_TOP  = 2'd3;

    stack_op_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .imm          (imm),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_top      (stk_top),
        .stk_din      (stk_din),
        .stk_dout     (stk_dout),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .depth        (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 256-entry LIFO, read data registered on the strobe edge
    logic [7:0] mem [256];
    int sp = 0;
    int stack_abuse = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp       <= 0;
            stk_dout <= 8'h00;
        end else if (stk_push) begin
            if (sp < 256) mem[8'(sp)] <= stk_din;
            else          stack_abuse <= stack_abuse + 1;
            sp <= sp + 1;
        end else if (stk_pop) begin
            if (sp > 0) begin
                stk_dout <= mem[8'(sp - 1)];
                sp       <= sp - 1;
            end else begin
                stack_abuse <= stack_abuse + 1;
            end
        end else if (stk_top) begin
            if (sp > 0) stk_dout <= mem[8'(sp - 1)];
            else        stack_abuse <= stack_abuse + 1;
        end
    end

    // Reference model state
    logic [7:0] mq[$];
    logic       model_err;
    logic [7:0] model_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic do_reset();
        instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_flags", 32'({instr_ready, stk_push, stk_pop, stk_top, result_valid, err}), 32'd0);
        chk("reset_din", 32'(stk_din), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_depth", 32'(depth), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        model_err = 1'b0;
        model_res = 8'h00;
    endtask

    // Issue one instruction and check strobes, timing and results against the model
    task automatic run_instr(input logic [2:0] op, input logic [7:0] im);
        int need, lat, n, rv_cycle, rv_count, multi, din_bad;
        bit grows, legal;
        logic [11:0] pat_e, pat_a;
        logic [7:0] exp_din, din_seen, a, b;
        logic ready_c1, err_c1;
        need = 0; grows = 0; lat = 0; pat_e = '0; exp_din = 8'h00; din_seen = 8'h00;
        case (op)
            OP_PUSH:         grows = 1;
            OP_POP, OP_PEEK: need = 1;
            OP_DUP:          begin need = 1; grows = 1; end
            default:         need = 2;
        endcase
        legal = (mq.size() >= need) && !(grows && mq.size() >= 256);
        if (!legal) model_err = 1'b1;
        else begin
            case (op)
                OP_PUSH: begin
                    mq.push_back(im); model_res = im; lat = 1;
                    pat_e[1:0] = P_PUSH; exp_din = im;
                end
                OP_POP: begin
                    model_res = mq.pop_back(); lat = 2; pat_e[1:0] = P_POP;
                end
                OP_PEEK: begin
                    model_res = mq[$]; lat = 2; pat_e[1:0] = P_TOP;
                end
                OP_DUP: begin
                    model_res = mq[$]; mq.push_back(model_res); lat = 3;
                    pat_e[1:0] = P_TOP; pat_e[5:4] = P_PUSH; exp_din = model_res;
                end
                default: begin
                    b = mq.pop_back(); a = mq.pop_back();
                    model_res = alu_ref(op, a, b); mq.push_back(model_res); lat = 4;
                    pat_e[1:0] = P_POP; pat_e[3:2] = P_POP; pat_e[7:6] = P_PUSH;
                    exp_din = model_res;
                end
            endcase
        end

        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        opcode = op;
        imm = im;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        opcode = 3'($urandom);
        imm = 8'($urandom);

        rv_cycle = 0; rv_count = 0; multi = 0; din_bad = 0; pat_a = '0;
        ready_c1 = 1'b0; err_c1 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ready_c1 = instr_ready;
                err_c1 = err;
            end
            if (int'(stk_push) + int'(stk_pop) + int'(stk_top) > 1) multi++;
            if (!stk_push && stk_din != 8'h00) din_bad++;
            if (stk_push) begin
                pat_a[2*(c-1) +: 2] = P_PUSH;
                din_seen = stk_din;
            end else if (stk_pop) begin
                pat_a[2*(c-1) +: 2] = P_POP;
            end else if (stk_top) begin
                pat_a[2*(c-1) +: 2] = P_TOP;
            end
            if (result_valid) begin
                rv_count++;
                if (rv_cycle == 0) rv_cycle = c;
            end
        end

        chk("strobe_sequence", 32'(pat_a), 32'(pat_e));
        chk("strobe_onehot", 32'(multi), 32'd0);
        chk("din_zero_without_push", 32'(din_bad), 32'd0);
        chk("push_data", 32'(din_seen), 32'(exp_din));
        chk("result_valid_cycle", 32'(rv_cycle), legal ? 32'(lat + 1) : 32'd0);
        chk("result_valid_count", 32'(rv_count), legal ? 32'd1 : 32'd0);
        chk("result", 32'(result), 32'(model_res));
        chk("depth", 32'(depth), 32'(mq.size()));
        chk("err", 32'(err), 32'(model_err));
        chk("ready_after_accept", 32'(ready_c1), legal ? 32'd0 : 32'd1);
        chk("err_after_accept", 32'(err_c1), 32'(model_err));
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] im;
        logic [7:0] res;
        logic [8:0] dep;
        logic       e;
    } vec_t;

    vec_t       tbl [22];
    int         n;
    logic       rv;
    logic [2:0] rop;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{OP_PUSH, 8'h05, 8'h05, 9'd1, 1'b0};
        tbl[1]  = '{OP_PUSH, 8'h03, 8'h03, 9'd2, 1'b0};
        tbl[2]  = '{OP_ADD,  8'h00, 8'h08, 9'd1, 1'b0};
        tbl[3]  = '{OP_POP,  8'h00, 8'h08, 9'd0, 1'b0};
        tbl[4]  = '{OP_PUSH, 8'h03, 8'h03, 9'd1, 1'b0};
        tbl[5]  = '{OP_PUSH, 8'h05, 8'h05, 9'd2, 1'b0};
        tbl[6]  = '{OP_SUB,  8'h00, 8'hFE, 9'd1, 1'b0};
        tbl[7]  = '{OP_PUSH, 8'hF0, 8'hF0, 9'd2, 1'b0};
        tbl[8]  = '{OP_PUSH, 8'h20, 8'h20, 9'd3, 1'b0};
        tbl[9]  = '{OP_ADD,  8'h00, 8'h10, 9'd2, 1'b0};
        tbl[10] = '{OP_POP,  8'h00, 8'h10, 9'd1, 1'b0};
        tbl[11] = '{OP_POP,  8'h00, 8'hFE, 9'd0, 1'b0};
        tbl[12] = '{OP_POP,  8'h00, 8'hFE, 9'd0, 1'b1};
        tbl[13] = '{OP_PUSH, 8'h07, 8'h07, 9'd1, 1'b1};
        tbl[14] = '{OP_POP,  8'h00, 8'h07, 9'd0, 1'b1};
        tbl[15] = '{OP_PUSH, 8'hAA, 8'hAA, 9'd1, 1'b1};
        tbl[16] = '{OP_DUP,  8'h00, 8'hAA, 9'd2, 1'b1};
        tbl[17] = '{OP_PEEK, 8'h00, 8'hAA, 9'd2, 1'b1};
        tbl[18] = '{OP_PUSH, 8'h0F, 8'h0F, 9'd3, 1'b1};
        tbl[19] = '{OP_AND,  8'h00, 8'h0A, 9'd2, 1'b1};
        tbl[20] = '{OP_OR,   8'h00, 8'hAA, 9'd1, 1'b1};
        tbl[21] = '{OP_POP,  8'h00, 8'hAA, 9'd0, 1'b1};

        rst = 1'b0;
        instr_valid = 1'b0;
        opcode = 3'd0;
        imm = 8'h00;
        #1;

        // Directed table
        do_reset();
        for (int i = 0; i < 22; i++) begin
            run_instr(tbl[i].op, tbl[i].im);
            chk($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].res));
            chk($sformatf("tbl%0d_depth", i), 32'(depth), 32'(tbl[i].dep));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e));
        end

        // Fill to capacity, then overflow attempts
        do_reset();
        for (int i = 0; i < 256; i++) run_instr(OP_PUSH, 8'(i));
        chk("full_depth", 32'(depth), 32'd256);
        chk("full_no_err", 32'(err), 32'd0);
        run_instr(OP_PUSH, 8'h55);
        run_instr(OP_DUP, 8'h00);
        chk("full_err", 32'(err), 32'd1);
        chk("full_depth_kept", 32'(depth), 32'd256);
        run_instr(OP_POP, 8'h00);
        chk("full_pop_value", 32'(result), 32'h0000_00FF);

        // Reset during RD_A of an ADD
        do_reset();
        run_instr(OP_PUSH, 8'h01);
        run_instr(OP_PUSH, 8'h02);
        @(negedge clk);
        instr_valid = 1'b1;
        opcode = OP_ADD;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rda_second_pop", 32'(stk_pop), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_strobes", 32'({stk_push, stk_pop, stk_top}), 32'd0);
        chk("midrst_depth", 32'(depth), 32'd0);
        chk("midrst_ready", 32'(instr_ready), 32'd0);
        rv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            rv = rv | result_valid;
        end
        chk("midrst_no_result_valid", 32'(rv), 32'd0);
        rst = 1'b0;
        mq.delete();
        model_err = 1'b0;
        model_res = 8'h00;
        n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_after_release", 32'(instr_ready), 32'd1);
        run_instr(OP_PUSH, 8'h01);
        chk("push_after_release", 32'(result), 32'h0000_0001);

        // Random instruction stream against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (mq.size() < 2 && $urandom_range(0, 1) == 1) rop = OP_PUSH;
            run_instr(rop, 8'($urandom));
        end

        chk("stack_never_misused", 32'(stack_abuse), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
